// File: rtl/pipe_pkg.sv
// Shared widths, forwarding encodings and the ID/EX register layout for the RV32I pipeline.
package pipe_pkg;

   localparam int XLEN   = 32;
   localparam int REG_W  = 5;
   localparam int ALUC_W = 3;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              alu_src;
      logic [ALUC_W-1:0] alu_ctrl;
   } idex_ctrl_t;

   // An all-zero idex_t is an architectural NOP.
   typedef struct packed {
      logic [XLEN-1:0]  rd1;
      logic [XLEN-1:0]  rd2;
      logic [XLEN-1:0]  imm;
      logic [XLEN-1:0]  pc;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rdst;
      idex_ctrl_t       ctrl;
   } idex_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/fwd_mux3.sv
// Three-source operand select driven by a forwarding code; the reserved code falls back to the register file.
module fwd_mux3
   import pipe_pkg::*;
#(
   parameter int W = XLEN
) (
   input  logic [1:0]   sel,
   input  logic [W-1:0] rf_val,
   input  logic [W-1:0] wb_val,
   input  logic [W-1:0] mem_val,
   output logic [W-1:0] y
);

   always_comb begin
      y = rf_val;
      case (sel)
         FWD_MEM: y = mem_val;
         FWD_WB:  y = wb_val;
         default: y = rf_val;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and forwarded Execute operands.
// Optional hazard counters (stall_cnt, flush_cnt) are built when HAZARD_STATS_EN is defined.
module id_ex_stage
   import pipe_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   rd1_d,
   input  logic [XLEN-1:0]   rd2_d,
   input  logic [XLEN-1:0]   imm_d,
   input  logic [XLEN-1:0]   pc_d,
   input  logic [REG_W-1:0]  rs1_d,
   input  logic [REG_W-1:0]  rs2_d,
   input  logic [REG_W-1:0]  rdst_d,
   input  logic              reg_write_d,
   input  logic              mem_read_d,
   input  logic              mem_write_d,
   input  logic              alu_src_d,
   input  logic [ALUC_W-1:0] alu_ctrl_d,
   input  logic              pc_src_e,
   input  logic [1:0]        forward_a_e,
   input  logic [1:0]        forward_b_e,
   input  logic [XLEN-1:0]   alu_result_m,
   input  logic [XLEN-1:0]   result_w,
   output logic [REG_W-1:0]  rs1_e,
   output logic [REG_W-1:0]  rs2_e,
   output logic [REG_W-1:0]  rdst_e,
   output logic              reg_write_e,
   output logic              mem_read_e,
   output logic              mem_write_e,
   output logic [ALUC_W-1:0] alu_ctrl_e,
   output logic [XLEN-1:0]   pc_e,
   output logic [XLEN-1:0]   imm_e,
   output logic [XLEN-1:0]   src_a_e,
   output logic [XLEN-1:0]   src_b_e,
   output logic [XLEN-1:0]   write_data_e,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_d
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   idex_t ex_q;
   idex_t ex_d;
   logic  lw_stall;
   logic  bubble;

   // x0 is never a real producer, so a load into it cannot create a hazard.
   assign lw_stall = ex_q.ctrl.mem_read && (ex_q.rdst != '0) &&
                     ((ex_q.rdst == rs1_d) || (ex_q.rdst == rs2_d));
   assign bubble   = lw_stall || pc_src_e;
   assign stall_f  = lw_stall && !pc_src_e;
   assign stall_d  = stall_f;
   assign flush_d  = pc_src_e;

   always_comb begin
      ex_d = '0;
      if (!bubble) begin
         ex_d.rd1            = rd1_d;
         ex_d.rd2            = rd2_d;
         ex_d.imm            = imm_d;
         ex_d.pc             = pc_d;
         ex_d.rs1            = rs1_d;
         ex_d.rs2            = rs2_d;
         ex_d.rdst           = rdst_d;
         ex_d.ctrl.reg_write = reg_write_d;
         ex_d.ctrl.mem_read  = mem_read_d;
         ex_d.ctrl.mem_write = mem_write_d;
         ex_d.ctrl.alu_src   = alu_src_d;
         ex_d.ctrl.alu_ctrl  = alu_ctrl_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign rs1_e       = ex_q.rs1;
   assign rs2_e       = ex_q.rs2;
   assign rdst_e      = ex_q.rdst;
   assign reg_write_e = ex_q.ctrl.reg_write;
   assign mem_read_e  = ex_q.ctrl.mem_read;
   assign mem_write_e = ex_q.ctrl.mem_write;
   assign alu_ctrl_e  = ex_q.ctrl.alu_ctrl;
   assign pc_e        = ex_q.pc;
   assign imm_e       = ex_q.imm;

   fwd_mux3 #(.W(XLEN)) u_fwd_a (
      .sel     (forward_a_e),
      .rf_val  (ex_q.rd1),
      .wb_val  (result_w),
      .mem_val (alu_result_m),
      .y       (src_a_e)
   );

   fwd_mux3 #(.W(XLEN)) u_fwd_b (
      .sel     (forward_b_e),
      .rf_val  (ex_q.rd2),
      .wb_val  (result_w),
      .mem_val (alu_result_m),
      .y       (write_data_e)
   );

   assign src_b_e = ex_q.ctrl.alu_src ? ex_q.imm : write_data_e;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;
   logic [31:0] flush_cnt_q;
   logic [31:0] flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_f) begin
         stall_cnt_d = sat_inc32(stall_cnt_q);
      end
      if (pc_src_e) begin
         flush_cnt_d = sat_inc32(flush_cnt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and execute-stage operand selection for the 5-stage RV32I pipeline.
- Captures decoded operands and control from Decode each cycle.
- Detects load-use hazards, generating stall/flush requests for Fetch/Decode.
- Applies the 2-bit forwarding selects from the forwarding unit to produce ALU source operands and store data for Execute.

Parameters:
- XLEN, 32, datapath width
- REG_W, 5, register-index width
- ALUC_W, 3, ALU control width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- rd1_d  in  XLEN  Decode register-file read 1
- rd2_d  in  XLEN  Decode register-file read 2
- imm_d  in  XLEN  Decode extended immediate
- pc_d  in  XLEN  Decode PC
- rs1_d  in  REG_W  Decode source 1 index
- rs2_d  in  REG_W  Decode source 2 index
- rdst_d  in  REG_W  Decode destination index
- reg_write_d, mem_read_d, mem_write_d, alu_src_d  in  1 each  Decode control
- alu_ctrl_d  in  ALUC_W  Decode ALU op
- pc_src_e  in  1  branch/jump taken, resolved in Execute
- forward_a_e, forward_b_e  in  2 each  forwarding selects
- alu_result_m  in  XLEN  Memory-stage ALU result
- result_w  in  XLEN  Writeback result
- rs1_e, rs2_e, rdst_e  out  REG_W  registered indices, to forwarding unit and downstream
- reg_write_e, mem_read_e, mem_write_e  out  1  registered control
- alu_ctrl_e  out  ALUC_W  registered ALU op
- pc_e, imm_e  out  XLEN  registered
- src_a_e  out  XLEN  forwarded ALU operand A
- src_b_e  out  XLEN  ALU operand B (immediate or forwarded)
- write_data_e  out  XLEN  forwarded store data
- stall_f, stall_d  out  1  hold PC and IF/ID
- flush_d  out  1  clear IF/ID

Behaviour:
- Reset (synchronous): every registered field cleared to 0 on the next clk edge, including all control bits and indices. Outputs after reset: src_a_e = 0, src_b_e = 0, write_data_e = 0.
- lw_stall (combinational) = mem_read_e & (rdst_e != 0) & ((rdst_e == rs1_d) | (rdst_e == rs2_d)).
- stall_f = stall_d = lw_stall & ~pc_src_e.
- flush_d = pc_src_e.
- bubble = lw_stall | pc_src_e. On bubble, the register loads all zeros: an architectural NOP with reg_write_e = 0, mem_read_e = 0, mem_write_e = 0, rdst_e = 0.
- Otherwise the register loads all *_d inputs every cycle; there is no enable.
- Priority: reset > bubble > load.
- Load-use latency is exactly one bubble cycle. The dependent instruction enters Execute one cycle late and receives the load data via result_w (forward 01).
- Forward mux A:
  - 00 -> registered rd1
  - 10 -> alu_result_m
  - 01 -> result_w
  - 11 -> registered rd1 (reserved)
- write_data_e is the same mux applied with forward_b_e and registered rd2.
- src_b_e = alu_src_e ? imm_e : write_data_e.
- All three operand outputs are combinational from registered state plus M/W inputs; there is no extra latency.
- Index 0 as destination never triggers a stall.
- pc_src_e together with lw_stall: the flush wins, stalls are deasserted, and a bubble is inserted.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined: adds outputs stall_cnt (32) and flush_cnt (32).
  - stall_cnt increments in each cycle where stall_f = 1.
  - flush_cnt increments in each cycle where pc_src_e = 1.
  - Both saturate at 32'hFFFF_FFFF and are cleared by reset.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg holds:
  - XLEN, REG_W, ALUC_W
  - forwarding encodings FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10
  - a packed struct for the ID/EX control bundle
- Sub-module fwd_mux3: XLEN-wide 3-source select on a 2-bit code, instantiated twice (A and B).

Test Plan:
- Reset: assert reset with all *_d nonzero, then release -> all *_e outputs 0 and stall_f = 0.
- Plain pass-through: rd1_d = 32'h11, rd2_d = 32'h22, alu_src_d = 0, forwards 00 -> next cycle src_a_e = 32'h11, src_b_e = 32'h22.
- Forwarding:
  - forward_a_e = 10 with alu_result_m = 32'hA5A5 -> src_a_e = 32'hA5A5.
  - forward_b_e = 01 with result_w = 32'h5A5A and alu_src_e = 0 -> src_b_e = write_data_e = 32'h5A5A.
- Load-use: mem_read_e = 1, rdst_e = 5, rs2_d = 5 -> stall_f = stall_d = 1 for exactly one cycle; next-cycle reg_write_e = 0 and mem_write_e = 0; following cycle the held instruction appears.
- x0 load: mem_read_e = 1, rdst_e = 0, rs1_d = 0 -> no stall.
- Branch flush: pc_src_e = 1 concurrent with a load-use condition -> flush_d = 1, stall_f = 0, bubble inserted. Under HAZARD_STATS_EN, flush_cnt increments by 1 and stall_cnt is unchanged.
